comparator_search_ctrl: RTL

- Initiator side of the comparator interface. It drives the probe operand `a` of an external magnitude comparator and consumes that comparator's one-hot g/e/l result.
- It runs a binary search to recover the unknown operand `b` (the target), which is held at the comparator's other input.
- Reports the found value, or an error, with a start/busy/done handshake.
- Sits beside any comparator instance of matching width. Expects the comparator to be purely combinational, giving a same-cycle response.

---
 rtl/comparator_search_pkg.sv | 17 +
 rtl/comparator_search_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/comparator_search_pkg.sv
// Shared definitions for the comparator binary-search controller.
//   state_t    : controller state (IDLE, EVAL, DONE), 2-bit encoding.
//   max_probes : most comparator probes an honest search can need for a
//                given operand width (the search space halves per probe).
package comparator_search_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int max_probes(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/comparator_search_ctrl.sv
// Binary-search initiator for an external combinational magnitude comparator.
// The controller drives the comparator's `a` operand with a probe value. It
// narrows [lo, hi] from the one-hot g/e/l answer until the hidden `b` operand
// (the target) is located, or until the answers become inconsistent.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request a search (sampled only while idle)
//   probe           value presented to comparator input `a`
//   cmp_g/e/l       comparator result (probe >, ==, < target)
//   busy            high while probing
//   done            one-cycle pulse when a search ends
//   found, err      outcome flags, valid with done and held afterwards
//   result          located value, held until the next accepted start
module comparator_search_ctrl
  import comparator_search_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_l,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  // Bounds carry one extra bit so that mid+1 past the top of the range and
  // the initial full-range hi are representable without wrapping.
  localparam int BW = WIDTH + 1;
  localparam logic [BW-1:0] FULL = {1'b0, {WIDTH{1'b1}}};

  state_t        state;
  logic [BW-1:0] lo;
  logic [BW-1:0] hi;

  function automatic logic [WIDTH-1:0] mid_of(input logic [BW-1:0] l,
                                              input logic [BW-1:0] h);
    logic [WIDTH+1:0] s;
    s = {1'b0, l} + {1'b0, h};
    s = s >> 1;
    return s[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] mid;
  logic [BW-1:0]    hi_dec;
  logic [BW-1:0]    lo_inc;
  logic             one_hot;

  assign mid     = mid_of(lo, hi);
  assign hi_dec  = {1'b0, mid} - BW'(1);
  assign lo_inc  = {1'b0, mid} + BW'(1);
  assign one_hot = $onehot({cmp_g, cmp_e, cmp_l});

  // probe is registered with the midpoint of the bounds it will face next,
  // so during EVAL it always equals mid of the current [lo, hi].
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            lo     <= '0;
            hi     <= FULL;
            probe  <= mid_of('0, FULL);
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b1;
            state  <= EVAL;
          end
        end

        EVAL: begin
          if (!one_hot) begin
            // Malformed answer: bounds are left untouched.
            err   <= 1'b1;
            found <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (cmp_e) begin
            result <= probe;
            found  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (cmp_g) begin
            hi <= hi_dec;
            // mid==0 would wrap hi_dec to all ones and evade the hi<lo test.
            if (mid == '0 || hi_dec < lo) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              probe <= mid_of(lo, hi_dec);
            end
          end else begin
            lo <= lo_inc;
            if (lo_inc > hi) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              probe <= mid_of(lo_inc, hi);
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
